// File: rtl/contador_segundos.sv
// contador_segundos
// Two-digit BCD up/down seconds counter with a built-in clock prescaler and
// a run-control state machine. It feeds the seven-segment digit decoders:
// the tens digit goes to the tens decoder and the units digit goes to the
// units decoder. Digits are plain BCD, and segment polarity is handled
// downstream.
//
// Parameters:
//   PRESCALE  - clock cycles per count step (>= 1, 1 = step every cycle)
//   MAX_VALUE - terminal count in decimal (1..99)
//   WRAP      - 1 = roll over at the terminal count, 0 = hold there and stop
//
// Ports:
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   start            level; moves IDLE to COUNT
//   stop             level; moves COUNT to IDLE (wins over start)
//   up               count direction, sampled at each step
//   load             loads ld_dez/ld_uni when the value is legal
//   ld_dez, ld_uni   BCD load value (tens, units)
//   dq4..dq1         tens digit, MSB..LSB
//   uq4..uq1         units digit, MSB..LSB
//   tick             one-cycle pulse alongside each digit update
//   tc               one-cycle pulse on terminal rollover or terminal stop
//   running          high while in COUNT
module contador_segundos #(
    parameter int PRESCALE  = 50000000,
    parameter int MAX_VALUE = 59,
    parameter int WRAP      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] ld_dez,
    input  logic [3:0] ld_uni,
    output logic       dq4,
    output logic       dq3,
    output logic       dq2,
    output logic       dq1,
    output logic       uq4,
    output logic       uq3,
    output logic       uq2,
    output logic       uq1,
    output logic       tick,
    output logic       tc,
    output logic       running
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [3:0]     MAX_DEZ    = 4'(MAX_VALUE / 10);
    localparam logic [3:0]     MAX_UNI    = 4'(MAX_VALUE % 10);
    localparam logic [7:0]     MAX_BIN    = 8'(MAX_VALUE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    dez, dez_nxt;
    logic [3:0]    uni, uni_nxt;
    logic          tick_nxt, tc_nxt;
    logic [7:0]    ld_bin;
    logic          load_ok;
    logic          at_max, at_zero;

    // The load value is checked against the terminal count in binary. This
    // value is only used for the check and never reaches the digit registers.
    assign ld_bin  = ({4'd0, ld_dez} * 8'd10) + {4'd0, ld_uni};
    assign load_ok = (ld_dez <= 4'd9) && (ld_uni <= 4'd9) && (ld_bin <= MAX_BIN);

    assign at_max  = (dez == MAX_DEZ) && (uni == MAX_UNI);
    assign at_zero = (dez == 4'd0) && (uni == 4'd0);

    // Next-state logic. A legal load overrides everything except reset.
    // An illegal load falls through as if load were low. Stepping is done
    // one BCD digit at a time, so the digits never pass through A-F.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        dez_nxt   = dez;
        uni_nxt   = uni;
        tick_nxt  = 1'b0;
        tc_nxt    = 1'b0;

        if (load && load_ok) begin
            dez_nxt   = ld_dez;
            uni_nxt   = ld_uni;
            state_nxt = ST_IDLE;
            presc_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    presc_nxt = '0;
                    if (start && !stop) begin
                        state_nxt = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                        presc_nxt = '0;
                    end else if (presc == PRESC_LAST) begin
                        presc_nxt = '0;
                        tick_nxt  = 1'b1;
                        if (up) begin
                            if (at_max) begin
                                tc_nxt = 1'b1;
                                if (WRAP != 0) begin
                                    dez_nxt = 4'd0;
                                    uni_nxt = 4'd0;
                                end else begin
                                    state_nxt = ST_DONE;
                                end
                            end else if (uni == 4'd9) begin
                                uni_nxt = 4'd0;
                                dez_nxt = dez + 4'd1;
                            end else begin
                                uni_nxt = uni + 4'd1;
                            end
                        end else begin
                            if (at_zero) begin
                                tc_nxt = 1'b1;
                                if (WRAP != 0) begin
                                    dez_nxt = MAX_DEZ;
                                    uni_nxt = MAX_UNI;
                                end else begin
                                    state_nxt = ST_DONE;
                                end
                            end else if (uni == 4'd0) begin
                                uni_nxt = 4'd9;
                                dez_nxt = dez - 4'd1;
                            end else begin
                                uni_nxt = uni - 4'd1;
                            end
                        end
                    end else begin
                        presc_nxt = presc + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Frozen until a legal load or reset.
                end
                default: begin
                    state_nxt = ST_IDLE;
                    presc_nxt = '0;
                end
            endcase
        end
    end

    // All state and outputs are registered. running follows the state that
    // is being entered, so it lines up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            presc   <= '0;
            dez     <= 4'd0;
            uni     <= 4'd0;
            tick    <= 1'b0;
            tc      <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            dez     <= dez_nxt;
            uni     <= uni_nxt;
            tick    <= tick_nxt;
            tc      <= tc_nxt;
            running <= (state_nxt == ST_COUNT);
        end
    end

    assign {dq4, dq3, dq2, dq1} = dez;
    assign {uq4, uq3, uq2, uq1} = uni;

endmodule

// File: tb/tb_contador_segundos.sv
// tb_contador_segundos
// Drives three contador_segundos instances from the same stimulus:
//   a: PRESCALE=4, MAX_VALUE=59, WRAP=1
//   b: PRESCALE=4, MAX_VALUE=59, WRAP=0
//   c: PRESCALE=1, MAX_VALUE=45, WRAP=1
// Each instance is compared every cycle against a behavioural model. The
// model keeps the count as a plain integer and counts cycles since the
// last step. It runs a directed sequence first and then randomized stimulus.
module tb_contador_segundos;

    localparam int NDUT = 3;

    localparam int PRE_A = 4;
    localparam int MAX_A = 59;
    localparam int WRAP_A = 1;
    localparam int PRE_B = 4;
    localparam int MAX_B = 59;
    localparam int WRAP_B = 0;
    localparam int PRE_C = 1;
    localparam int MAX_C = 45;
    localparam int WRAP_C = 1;

    int    cfg_pre  [NDUT] = '{PRE_A, PRE_B, PRE_C};
    int    cfg_max  [NDUT] = '{MAX_A, MAX_B, MAX_C};
    int    cfg_wrap [NDUT] = '{WRAP_A, WRAP_B, WRAP_C};
    string cfg_tag  [NDUT] = '{"a_p4_m59_wrap", "b_p4_m59_hold", "c_p1_m45_wrap"};

    logic       clk = 1'b0;
    logic       reset, start, stop, up, load;
    logic [3:0] ld_dez, ld_uni;

    wire [3:0] dz_a, un_a, dz_b, un_b, dz_c, un_c;
    wire       tk_a, tc_a, rn_a, tk_b, tc_b, rn_b, tk_c, tc_c, rn_c;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state per instance: value is the decimal count, mode is
    // 0 idle / 1 counting / 2 done, and phase counts cycles since the last step.
    int m_value [NDUT];
    int m_mode  [NDUT];
    int m_phase [NDUT];
    bit m_tick  [NDUT];
    bit m_tc    [NDUT];

    always #5 clk = ~clk;

    contador_segundos #(.PRESCALE(PRE_A), .MAX_VALUE(MAX_A), .WRAP(WRAP_A)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up(up), .load(load),
        .ld_dez(ld_dez), .ld_uni(ld_uni),
        .dq4(dz_a[3]), .dq3(dz_a[2]), .dq2(dz_a[1]), .dq1(dz_a[0]),
        .uq4(un_a[3]), .uq3(un_a[2]), .uq2(un_a[1]), .uq1(un_a[0]),
        .tick(tk_a), .tc(tc_a), .running(rn_a)
    );

    contador_segundos #(.PRESCALE(PRE_B), .MAX_VALUE(MAX_B), .WRAP(WRAP_B)) u_b (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up(up), .load(load),
        .ld_dez(ld_dez), .ld_uni(ld_uni),
        .dq4(dz_b[3]), .dq3(dz_b[2]), .dq2(dz_b[1]), .dq1(dz_b[0]),
        .uq4(un_b[3]), .uq3(un_b[2]), .uq2(un_b[1]), .uq1(un_b[0]),
        .tick(tk_b), .tc(tc_b), .running(rn_b)
    );

    contador_segundos #(.PRESCALE(PRE_C), .MAX_VALUE(MAX_C), .WRAP(WRAP_C)) u_c (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .up(up), .load(load),
        .ld_dez(ld_dez), .ld_uni(ld_uni),
        .dq4(dz_c[3]), .dq3(dz_c[2]), .dq2(dz_c[1]), .dq1(dz_c[0]),
        .uq4(un_c[3]), .uq3(un_c[2]), .uq2(un_c[1]), .uq1(un_c[0]),
        .tick(tk_c), .tc(tc_c), .running(rn_c)
    );

    // Observed outputs packed as {tens, units, tick, tc, running}.
    function automatic logic [10:0] observed(input int i);
        case (i)
            0:       return {dz_a, un_a, tk_a, tc_a, rn_a};
            1:       return {dz_b, un_b, tk_b, tc_b, rn_b};
            default: return {dz_c, un_c, tk_c, tc_c, rn_c};
        endcase
    endfunction

    function automatic logic [10:0] expected(input int i);
        logic [3:0] tens, units;
        tens  = 4'(m_value[i] / 10);
        units = 4'(m_value[i] % 10);
        return {tens, units, m_tick[i], m_tc[i], (m_mode[i] == 1)};
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("[TB] FAIL %s cycle %0d observed %b required %b (tens,units,tick,tc,running)",
                     tag, cyc, obs, exp_v);
        end
    endtask

    // One count step on the integer model.
    task automatic modelStep(input int i);
        m_tick[i] = 1'b1;
        if (up) begin
            if (m_value[i] == cfg_max[i]) begin
                m_tc[i] = 1'b1;
                if (cfg_wrap[i] != 0) m_value[i] = 0;
                else m_mode[i] = 2;
            end else begin
                m_value[i] = m_value[i] + 1;
            end
        end else begin
            if (m_value[i] == 0) begin
                m_tc[i] = 1'b1;
                if (cfg_wrap[i] != 0) m_value[i] = cfg_max[i];
                else m_mode[i] = 2;
            end else begin
                m_value[i] = m_value[i] - 1;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic modelEdge(input int i);
        int ld_val;
        bit ld_ok;
        ld_val = 10 * int'(ld_dez) + int'(ld_uni);
        ld_ok  = (ld_dez <= 4'd9) && (ld_uni <= 4'd9) && (ld_val <= cfg_max[i]);
        m_tick[i] = 1'b0;
        m_tc[i]   = 1'b0;
        if (reset) begin
            m_value[i] = 0;
            m_mode[i]  = 0;
            m_phase[i] = 0;
        end else if (load && ld_ok) begin
            m_value[i] = ld_val;
            m_mode[i]  = 0;
            m_phase[i] = 0;
        end else if (m_mode[i] == 0) begin
            if (start && !stop) m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
            if (stop) begin
                m_mode[i]  = 0;
                m_phase[i] = 0;
            end else begin
                m_phase[i] = m_phase[i] + 1;
                if (m_phase[i] == cfg_pre[i]) begin
                    m_phase[i] = 0;
                    modelStep(i);
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, update the models, then check
    // every instance shortly after the edge.
    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit l,
                                 input logic [3:0] d, input logic [3:0] n);
        reset  = r;
        start  = s;
        stop   = p;
        load   = l;
        ld_dez = d;
        ld_uni = n;
        @(posedge clk);
        for (int i = 0; i < NDUT; i++) modelEdge(i);
        #1;
        cyc++;
        for (int i = 0; i < NDUT; i++) checkOutput(cfg_tag[i], observed(i), expected(i));
    endtask

    task automatic runIdle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            m_value[i] = 0;
            m_mode[i]  = 0;
            m_phase[i] = 0;
            m_tick[i]  = 1'b0;
            m_tc[i]    = 1'b0;
        end
        reset = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b1; load = 1'b0;
        ld_dez = 4'd0; ld_uni = 4'd0;

        // Reset and quiet idle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(20);

        // Count up through a units carry, then stop
        up = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(40);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        runIdle(10);

        // Load 58 and count past the terminal value
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(10);

        // Load 00 and count down through zero, flipping direction mid-period
        up = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(6);
        up = 1'b1;
        runIdle(10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

        // Reach the terminal count with start held, then load out of DONE
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd8);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(12);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
        runIdle(3);

        // Illegal loads while counting
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0);
        runIdle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd10);
        runIdle(8);

        // Load on the same edge as a step of the prescaled instances
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5);
        runIdle(4);

        // Start and stop together in IDLE: stop wins
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        runIdle(2);

        // Reset while counting from 37
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd7);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(6);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        runIdle(3);

        // Randomized stimulus
        for (int k = 0; k < 3000; k++) begin
            bit r, s, p, l;
            logic [3:0] d, n;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 24) == 0);
            d = 4'($urandom_range(0, 11));
            n = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 29) == 0) up = ~up;
            applyStimulus(r, s, p, l, d, n);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
